// File: rtl/note_chart_sequencer.sv
// rtl/note_chart_sequencer.sv - steps through a chart ROM and pulses per-column note starts on game ticks
// Each ROM entry is {delta, colMask}; {0,0} ends the song.
module note_chart_sequencer #(
  parameter int NCOL    = 5,
  parameter int ADDR_W  = 8,
  parameter int DELTA_W = 8,
  parameter int TICK_W  = 16
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    gameTick,
  output logic [ADDR_W-1:0]       romAddr,
  input  logic [DELTA_W+NCOL-1:0] romData,
  output logic [NCOL-1:0]         noteStart,
  output logic                    songActive,
  output logic                    songDone,
  output logic [TICK_W-1:0]       tickCount
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_FIRE, S_DONE} state_t;

  localparam logic [TICK_W-1:0]  TICK_ONE  = 1;
  localparam logic [DELTA_W-1:0] DELTA_ONE = 1;
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [DELTA_W-1:0] r_remaining;
  logic [NCOL-1:0]    r_mask;
  logic [NCOL-1:0]    r_note;
  logic [TICK_W-1:0]  r_tick;
  logic [DELTA_W-1:0] w_delta;
  logic [NCOL-1:0]    w_mask;
  logic               w_tick_ok;
  logic               w_active;

  assign w_delta   = romData[DELTA_W+NCOL-1:NCOL];
  assign w_mask    = romData[NCOL-1:0];
  assign w_tick_ok = gameTick & ~pause;
  assign w_active  = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                     (r_state == S_WAIT)  || (r_state == S_FIRE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_FETCH: w_next = S_LOAD;
      S_LOAD: begin
        if (w_delta == '0 && w_mask == '0) w_next = S_DONE;
        else if (w_delta == '0)            w_next = S_FIRE;
        else                               w_next = S_WAIT;
      end
      S_WAIT:  if (w_tick_ok && r_remaining == DELTA_ONE) w_next = S_FIRE;
      S_FIRE:  w_next = (r_addr == ADDR_LAST) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    // Restart overrides every other transition, including leaving FIRE.
    if (start) w_next = S_FETCH;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_mask      <= '0;
      r_note      <= '0;
      r_tick      <= '0;
    end else begin
      r_state <= w_next;
      // A delta-0 entry fires straight from LOAD, before r_mask has captured it.
      if (w_next == S_FIRE) r_note <= (r_state == S_LOAD) ? w_mask : r_mask;
      else                  r_note <= '0;
      if (start) begin
        r_addr      <= '0;
        r_tick      <= '0;
        r_remaining <= '0;
      end else begin
        if (w_active && w_tick_ok) r_tick <= r_tick + TICK_ONE;
        case (r_state)
          S_LOAD: begin
            r_mask <= w_mask;
            if (w_delta != '0) r_remaining <= w_delta;
          end
          S_WAIT:  if (w_tick_ok) r_remaining <= r_remaining - DELTA_ONE;
          S_FIRE:  if (r_addr != ADDR_LAST) r_addr <= r_addr + ADDR_ONE;
          default: ;
        endcase
      end
    end
  end

  assign romAddr    = r_addr;
  assign noteStart  = r_note;
  assign songActive = w_active;
  assign songDone   = (r_state == S_DONE);
  assign tickCount  = r_tick;

endmodule
